// File: rtl/cntr_param_if.sv
// Command/status bundle for the parametrised counter core.
// The controller side drives the master modport; the counter core uses the slave modport.
interface cntr_param_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              en;
    logic              load;
    logic              inc;
    logic              dec;
    logic [WIDTH-1:0]  d_in;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  d_out;
    logic [2:0]        o_state;
    logic              wrap;

    modport master (
        output en, load, inc, dec, d_in, step,
        input  d_out, o_state, wrap
    );

    modport slave (
        input  en, load, inc, dec, d_in, step,
        output d_out, o_state, wrap
    );
endinterface

// File: rtl/cntr_param.sv
// Parametrised up/down/load counter with an operation FSM and a wrap/clamp flag.
// The o_state encoding is shared with the legacy counter so existing state decoders keep working.
//
// state | meaning
// IDLE  | out of reset, no command seen yet
// LOAD  | d_in captured into the count
// INC   | first increment after a different operation
// INC2  | consecutive increment
// DEC   | first decrement after a different operation
// DEC2  | consecutive decrement
// HOLD  | inc and dec together, or no command after leaving IDLE
// ILL   | never entered; recovers to IDLE with a cleared count
module cntr_param #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4,
    parameter bit SAT    = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    cntr_param_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_LOAD = 3'b001,
        ST_INC  = 3'b010,
        ST_INC2 = 3'b011,
        ST_DEC  = 3'b100,
        ST_DEC2 = 3'b101,
        ST_HOLD = 3'b110,
        ST_ILL  = 3'b111
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_wrap;

    logic [WIDTH-1:0] w_step;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_inc_val;
    logic [WIDTH-1:0] w_dec_val;

    // A zero step is treated as one so that every inc/dec actually moves the count.
    assign w_step = (bus.step == '0) ? WIDTH'(1) : WIDTH'(bus.step);

    assign w_sum  = {1'b0, r_count} + {1'b0, w_step};
    assign w_diff = {1'b0, r_count} - {1'b0, w_step};

    // Bit WIDTH is the carry (sum) or borrow (difference).
    assign w_inc_val = (w_sum[WIDTH] && SAT)  ? '1 : w_sum[WIDTH-1:0];
    assign w_dec_val = (w_diff[WIDTH] && SAT) ? '0 : w_diff[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (r_state == ST_ILL) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (!bus.en) begin
            r_wrap <= 1'b0;
        end else if (bus.load) begin
            r_state <= ST_LOAD;
            r_count <= bus.d_in;
            r_wrap  <= 1'b0;
        end else if (bus.inc && bus.dec) begin
            r_state <= ST_HOLD;
            r_wrap  <= 1'b0;
        end else if (bus.inc) begin
            r_state <= (r_state == ST_INC || r_state == ST_INC2) ? ST_INC2 : ST_INC;
            r_count <= w_inc_val;
            r_wrap  <= w_sum[WIDTH];
        end else if (bus.dec) begin
            r_state <= (r_state == ST_DEC || r_state == ST_DEC2) ? ST_DEC2 : ST_DEC;
            r_count <= w_dec_val;
            r_wrap  <= w_diff[WIDTH];
        end else begin
            r_state <= (r_state == ST_IDLE) ? ST_IDLE : ST_HOLD;
            r_wrap  <= 1'b0;
        end
    end

    assign bus.d_out   = r_count;
    assign bus.o_state = r_state;
    assign bus.wrap    = r_wrap;
endmodule

// File: tb/tb_cntr_param.sv
// Bench for cntr_param: three builds (8-bit wrap, 8-bit saturate, 16-bit wrap) driven in lockstep
// and compared every cycle against an arithmetic reference model.
module tb_cntr_param;
    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        load;
    logic        inc;
    logic        dec;
    logic [15:0] d_in;
    logic [3:0]  step;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cntr_param_if #(.WIDTH(8),  .STEP_W(4)) if_w ();
    cntr_param_if #(.WIDTH(8),  .STEP_W(4)) if_s ();
    cntr_param_if #(.WIDTH(16), .STEP_W(4)) if_l ();

    assign if_w.en = en;  assign if_w.load = load;  assign if_w.inc = inc;
    assign if_w.dec = dec; assign if_w.d_in = d_in[7:0]; assign if_w.step = step;
    assign if_s.en = en;  assign if_s.load = load;  assign if_s.inc = inc;
    assign if_s.dec = dec; assign if_s.d_in = d_in[7:0]; assign if_s.step = step;
    assign if_l.en = en;  assign if_l.load = load;  assign if_l.inc = inc;
    assign if_l.dec = dec; assign if_l.d_in = d_in;      assign if_l.step = step;

    cntr_param #(.WIDTH(8),  .STEP_W(4), .SAT(1'b0)) u_wrap8 (.clk(clk), .reset(reset), .bus(if_w.slave));
    cntr_param #(.WIDTH(8),  .STEP_W(4), .SAT(1'b1)) u_sat8  (.clk(clk), .reset(reset), .bus(if_s.slave));
    cntr_param #(.WIDTH(16), .STEP_W(4), .SAT(1'b0)) u_wrap16(.clk(clk), .reset(reset), .bus(if_l.slave));

    // Reference model: counts as plain integers, state as the published encoding.
    int c_w[3]   = '{8, 8, 16};
    int c_sat[3] = '{0, 1, 0};
    int m_cnt[3];
    int m_st[3];
    int m_wrap[3];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int maxv = (1 << c_w[k]) - 1;
            int s = (step == 4'd0) ? 1 : int'(step);
            int v;
            if (reset) begin
                m_cnt[k] = 0; m_st[k] = 0; m_wrap[k] = 0;
            end else if (!en) begin
                m_wrap[k] = 0;
            end else if (load) begin
                m_cnt[k] = int'(d_in) & maxv; m_st[k] = 1; m_wrap[k] = 0;
            end else if (inc && dec) begin
                m_st[k] = 6; m_wrap[k] = 0;
            end else if (inc) begin
                v = m_cnt[k] + s;
                m_wrap[k] = (v > maxv) ? 1 : 0;
                if (v > maxv) m_cnt[k] = c_sat[k] ? maxv : v - (maxv + 1);
                else          m_cnt[k] = v;
                m_st[k] = (m_st[k] == 2 || m_st[k] == 3) ? 3 : 2;
            end else if (dec) begin
                v = m_cnt[k] - s;
                m_wrap[k] = (v < 0) ? 1 : 0;
                if (v < 0) m_cnt[k] = c_sat[k] ? 0 : v + (maxv + 1);
                else       m_cnt[k] = v;
                m_st[k] = (m_st[k] == 4 || m_st[k] == 5) ? 5 : 4;
            end else begin
                m_st[k] = (m_st[k] == 0) ? 0 : 6; m_wrap[k] = 0;
            end
        end
    endtask

    task automatic check_all();
        check_val("w8_dout",   32'(if_w.d_out),   m_cnt[0]);
        check_val("w8_state",  32'(if_w.o_state), m_st[0]);
        check_val("w8_wrap",   32'(if_w.wrap),    m_wrap[0]);
        check_val("s8_dout",   32'(if_s.d_out),   m_cnt[1]);
        check_val("s8_state",  32'(if_s.o_state), m_st[1]);
        check_val("s8_wrap",   32'(if_s.wrap),    m_wrap[1]);
        check_val("w16_dout",  32'(if_l.d_out),   m_cnt[2]);
        check_val("w16_state", 32'(if_l.o_state), m_st[2]);
        check_val("w16_wrap",  32'(if_l.wrap),    m_wrap[2]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_in(input logic r, input logic e, input logic l, input logic i,
                          input logic dc, input logic [15:0] din, input logic [3:0] st);
        reset = r; en = e; load = l; inc = i; dec = dc; d_in = din; step = st;
    endtask

    logic [7:0] exp_d[3];
    logic [2:0] exp_s[3];
    logic       exp_w[3];

    initial begin
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
        for (int k = 0; k < 3; k++) begin m_cnt[k] = 0; m_st[k] = 0; m_wrap[k] = 0; end
        @(negedge clk);

        // Reset then load
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        tick(); tick();
        check_val("rst_dout",  32'(if_w.d_out),   32'h00);
        check_val("rst_state", 32'(if_w.o_state), 32'h0);
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h00A5, 4'h0);
        tick();
        check_val("ld_dout",  32'(if_w.d_out),   32'hA5);
        check_val("ld_state", 32'(if_w.o_state), 32'h1);
        check_val("ld_wrap",  32'(if_w.wrap),    32'h0);

        // Consecutive inc with step 0 across the 8-bit wrap point
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h00FE, 4'h0);
        tick();
        exp_d = '{8'hFF, 8'h00, 8'h01}; exp_s = '{3'b010, 3'b011, 3'b011}; exp_w = '{1'b0, 1'b1, 1'b0};
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("inc_seq_dout",  32'(if_w.d_out),   32'(exp_d[i]));
            check_val("inc_seq_state", 32'(if_w.o_state), 32'(exp_s[i]));
            check_val("inc_seq_wrap",  32'(if_w.wrap),    32'(exp_w[i]));
        end

        // Dec with step 3 through zero, then inc&dec hold
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 4'h0);
        tick();
        exp_d = '{8'hFE, 8'hFB, 8'hFB}; exp_s = '{3'b100, 3'b101, 3'b110}; exp_w = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b1, 1'b0, (i == 2), 1'b1, 16'h0, 4'h3);
            tick();
            check_val("dec_seq_dout",  32'(if_w.d_out),   32'(exp_d[i]));
            check_val("dec_seq_state", 32'(if_w.o_state), 32'(exp_s[i]));
            check_val("dec_seq_wrap",  32'(if_w.wrap),    32'(exp_w[i]));
        end

        // Saturating build: clamp at all-ones, repeated clamp, clamp at zero
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h00FC, 4'h0);
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 4'h7);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("sat_hi_dout", 32'(if_s.d_out), 32'hFF);
            check_val("sat_hi_wrap", 32'(if_s.wrap),  32'h1);
        end
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0002, 4'h0);
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 4'h5);
        tick();
        check_val("sat_lo_dout", 32'(if_s.d_out), 32'h00);
        check_val("sat_lo_wrap", 32'(if_s.wrap),  32'h1);

        // Priority and enable
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0033, 4'h0);
        tick();
        check_val("prio_dout",  32'(if_w.d_out),   32'h33);
        check_val("prio_state", 32'(if_w.o_state), 32'h1);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("en0_dout",  32'(if_w.d_out),   32'h33);
            check_val("en0_state", 32'(if_w.o_state), 32'h1);
            check_val("en0_wrap",  32'(if_w.wrap),    32'h0);
        end
        en = 1'b1;
        tick();
        check_val("en1_dout",  32'(if_w.d_out),   32'h34);
        check_val("en1_state", 32'(if_w.o_state), 32'h2);

        // Reset mid-count on the 16-bit build
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1233, 4'h0);
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        tick();
        check_val("mid_pre_dout", 32'(if_l.d_out), 32'h1234);
        reset = 1'b1;
        tick();
        check_val("mid_rst_dout",  32'(if_l.d_out),   32'h0000);
        check_val("mid_rst_state", 32'(if_l.o_state), 32'h0);
        check_val("mid_rst_wrap",  32'(if_l.wrap),    32'h0);
        reset = 1'b0;
        tick();
        check_val("mid_inc_dout",  32'(if_l.d_out),   32'h0001);
        check_val("mid_inc_state", 32'(if_l.o_state), 32'h2);

        // Randomized traffic, biased toward the wrap/clamp boundaries
        for (int n = 0; n < 600; n++) begin
            int sel;
            reset = ($urandom_range(0, 63) == 0);
            en    = ($urandom_range(0, 7) != 0);
            load  = ($urandom_range(0, 7) == 0);
            inc   = $urandom_range(0, 1) != 0;
            dec   = $urandom_range(0, 1) != 0;
            step  = 4'($urandom_range(0, 15));
            sel   = $urandom_range(0, 3);
            case (sel)
                0:       d_in = 16'h0000;
                1:       d_in = 16'hFFFF - 16'($urandom_range(0, 3));
                2:       d_in = 16'h00FF - 16'($urandom_range(0, 3));
                default: d_in = 16'($urandom);
            endcase
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cntr_param.md
Name: cntr_param

Overview:
- Parametrised up/down/load counter with a registered datapath and an explicit operation FSM. Next generation of the 8-bit counter: configurable width and step size, wrap or saturate mode, enable, and wrap/saturation flags.
- Sits in the counter subsystem as a drop-in counter core. The `o_state` encoding matches the existing counter FSM encoding, so downstream state decoders still work.

Parameters:
- WIDTH, 8, counter/data width in bits (>=2)
- STEP_W, 4, width of the step input (STEP_W <= WIDTH)
- SAT, 0, overflow mode: 0 = modulo wrap, 1 = saturate at all-ones / zero

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous reset, active-high
- en  input  1  count enable; 0 freezes all state
- load  input  1  load command
- inc  input  1  increment command
- dec  input  1  decrement command
- d_in  input  WIDTH  load value
- step  input  STEP_W  increment/decrement amount; 0 means 1
- d_out  output  WIDTH  registered count value
- o_state  output  3  current FSM state
- wrap  output  1  one-cycle pulse: the last update wrapped (SAT=0) or clamped (SAT=1)

Behaviour:
- Interface: one clock `clk`. `reset` is synchronous, active-high.
- Reset (at any time, including mid-count; has priority over everything):
  - d_out=0, o_state=IDLE, wrap=0.
- States: IDLE=3'b000, LOAD=3'b001, INC=3'b010, INC2=3'b011, DEC=3'b100, DEC2=3'b101, HOLD=3'b110. 3'b111 is unreachable; if entered, the next edge forces IDLE with d_out=0.
- All updates occur on the rising clk edge with en=1. Latency is 1 cycle: a command sampled at edge N is visible on d_out and o_state after edge N.
- en=0: d_out and o_state hold, wrap=0, commands are ignored.
- Command priority, when en=1:
  - load: d_out<=d_in, next state LOAD.
  - else inc&dec: d_out holds, next state HOLD.
  - else inc: d_out<=d_out+s. Next state INC if the current state is not INC/INC2, else INC2.
  - else dec: d_out<=d_out-s. Next state DEC if the current state is not DEC/DEC2, else DEC2.
  - else (no command): d_out holds. Next state HOLD, except that IDLE stays IDLE.
- Step s = zero-extended step to WIDTH bits; step==0 gives s=1.
- Arithmetic is computed at WIDTH+1 bits.
- SAT=0 (wrap):
  - Result is taken modulo 2^WIDTH.
  - wrap=1 for the single cycle after any inc carry-out or dec borrow.
- SAT=1 (saturate):
  - inc result > 2^WIDTH-1 clamps to all-ones; dec result < 0 clamps to 0.
  - wrap=1 for the cycle after any clamp, including an inc while already at all-ones or a dec while already at 0.
- wrap is 0 after load, HOLD, and idle cycles.
- A step change mid-count takes effect on the next edge. No other pipelining.
- inc in the same cycle as reset: reset wins (d_out=0, IDLE).

Test Plan (WIDTH=8, STEP_W=4 unless noted):
- Reset/load: reset=1 for 2 cycles -> d_out=0x00, o_state=000. Then load=1, d_in=0xA5 -> next cycle d_out=0xA5, o_state=001, wrap=0.
- Consecutive inc, step=0: from 0xFE, inc for 3 cycles ->
  - d_out sequence 0xFF, 0x00, 0x01
  - o_state sequence 010, 011, 011
  - wrap=1 only in the cycle d_out=0x00
- Dec with step=3, SAT=0: from 0x01, dec for 2 cycles -> d_out 0xFE then 0xFB, o_state 100 then 101, wrap pulse on 0xFE only. Then inc&dec together -> d_out holds 0xFB, o_state=110.
- SAT=1 clamp: load 0xFC, inc step=7 for 2 cycles -> d_out 0xFF, 0xFF with wrap=1 both cycles. Then load 0x02, dec step=5 -> d_out=0x00, wrap=1.
- Priority/enable:
  - load+inc+dec with d_in=0x33 -> d_out=0x33, o_state=001.
  - en=0 with inc held for 4 cycles -> d_out and o_state unchanged, wrap=0.
  - en back to 1 -> counting resumes, first state INC (010).
- Reset mid-count, WIDTH=16 build: incrementing at 0x1234, assert reset with inc=1 -> next cycle d_out=0x0000, o_state=000, wrap=0. After reset deasserts, the first inc gives d_out=0x0001, o_state=010.
